// File: rtl/rx_cmd_decoder.sv
// Framed ASCII command decoder: "#" <ch> <act> <CR|LF> drives per-channel level/pulse outputs.
// Optional ACK byte to the UART TX core when RX_CMD_ACK_EN is defined.
module rx_cmd_decoder #(
    parameter int CH_NUM      = 4,
    parameter int PULSE_LEN   = 8,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        po_data,
    input  logic              po_flag,
    output logic [CH_NUM-1:0] ch_level,
    output logic [CH_NUM-1:0] ch_pulse,
    output logic              cmd_ok,
    output logic              cmd_err,
    output logic              busy
`ifdef RX_CMD_ACK_EN
    ,
    output logic [7:0]        pi_data,
    output logic              pi_flag
`endif
);

    localparam logic [7:0] C_HASH = 8'h23;
    localparam logic [7:0] C_CR   = 8'h0D;
    localparam logic [7:0] C_LF   = 8'h0A;
    localparam logic [7:0] C_ONE  = 8'h31;
    localparam logic [7:0] CH_MAX = 8'(8'h30 + CH_NUM);
    localparam int         PW     = $clog2(PULSE_LEN + 1);
    localparam int         TW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Expiry fires on the edge where the idle count would reach TIMEOUT_CYC-1.
    localparam logic [TW-1:0] TO_LIM = (TIMEOUT_CYC > 2) ? TW'(TIMEOUT_CYC - 2) : '0;

    typedef enum logic [1:0] {IDLE, HDR, CH, ACT} state_t;
    typedef enum logic [1:0] {A_SET, A_CLR, A_TGL, A_PLS} act_t;

    state_t        state;
    act_t          act;
    logic [3:0]    idx;
    logic [TW-1:0] tcnt;
    logic [PW-1:0] pcnt [CH_NUM];

    logic is_hash, ch_ok, term_ok, timeout_hit, frame_ok, frame_err;

    function automatic logic valid_act(input logic [7:0] b);
        return b inside {8'h53, 8'h43, 8'h54, 8'h50};
    endfunction

    function automatic act_t decode_act(input logic [7:0] b);
        case (b)
            8'h53:   return A_SET;
            8'h43:   return A_CLR;
            8'h54:   return A_TGL;
            default: return A_PLS;
        endcase
    endfunction

    assign is_hash     = (po_data == C_HASH);
    assign ch_ok       = (po_data >= C_ONE) && (po_data <= CH_MAX);
    assign term_ok     = (po_data == C_CR) || (po_data == C_LF);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (state != IDLE) && !po_flag && (tcnt >= TO_LIM);
    assign frame_ok    = po_flag && !is_hash && (state == ACT) && term_ok;
    assign frame_err   = timeout_hit ||
                         (po_flag && !is_hash &&
                          (((state == HDR) && !ch_ok) ||
                           ((state == CH)  && !valid_act(po_data)) ||
                           ((state == ACT) && !term_ok)));
    assign busy        = (state != IDLE);

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) ch_pulse[i] = (pcnt[i] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            act      <= A_SET;
            idx      <= '0;
            tcnt     <= '0;
            ch_level <= '0;
            cmd_ok   <= 1'b0;
            cmd_err  <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) pcnt[i] <= '0;
        end else begin
            cmd_ok  <= frame_ok;
            cmd_err <= frame_err;

            if (po_flag || (state == IDLE) || timeout_hit) tcnt <= '0;
            else                                           tcnt <= tcnt + 1'b1;

            if (frame_ok || frame_err) begin
                state <= IDLE;
            end else if (po_flag) begin
                if (is_hash) begin
                    state <= HDR;
                end else if (state == HDR) begin
                    state <= CH;
                    idx   <= 4'(po_data - C_ONE);
                end else if (state == CH) begin
                    state <= ACT;
                    act   <= decode_act(po_data);
                end
            end

            // A reload takes priority over the countdown so a re-pulse has no low gap.
            for (int i = 0; i < CH_NUM; i++) begin
                if (frame_ok && (idx == 4'(i))) begin
                    case (act)
                        A_SET:   ch_level[i] <= 1'b1;
                        A_CLR:   ch_level[i] <= 1'b0;
                        A_TGL:   ch_level[i] <= ~ch_level[i];
                        default: ;
                    endcase
                end
                if (frame_ok && (idx == 4'(i)) && (act == A_PLS)) pcnt[i] <= PW'(PULSE_LEN);
                else if (pcnt[i] != '0)                           pcnt[i] <= pcnt[i] - 1'b1;
            end
        end
    end

`ifdef RX_CMD_ACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_data <= 8'h00;
            pi_flag <= 1'b0;
        end else begin
            pi_flag <= frame_ok || frame_err;
            if (frame_ok)       pi_data <= 8'h4B;
            else if (frame_err) pi_data <= 8'h45;
        end
    end
`endif

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Randomized self-checking bench for rx_cmd_decoder against a frame-buffer reference model.
// Builds with or without RX_CMD_ACK_EN.
module tb_rx_cmd_decoder;

    localparam int CH = 4;
    localparam int PL = 8;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    po_data = 8'h00;
    logic          po_flag = 1'b0;
    logic [CH-1:0] ch_level, ch_pulse;
    logic          cmd_ok, cmd_err, busy;
`ifdef RX_CMD_ACK_EN
    logic [7:0]    pi_data;
    logic          pi_flag;
`endif

    always #5 clk = ~clk;

    rx_cmd_decoder #(.CH_NUM(CH), .PULSE_LEN(PL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .po_data(po_data), .po_flag(po_flag),
        .ch_level(ch_level), .ch_pulse(ch_pulse), .cmd_ok(cmd_ok), .cmd_err(cmd_err),
`ifdef RX_CMD_ACK_EN
        .pi_data(pi_data), .pi_flag(pi_flag),
`endif
        .busy(busy)
    );

    // Reference model: bytes of the current frame, remaining pulse time, idle cycles.
    logic [CH-1:0] m_level;
    int            m_pulse [CH];
    logic          m_ok, m_err;
    logic [7:0]    m_ack;
    logic [7:0]    fr [$];
    int            m_idle;

    int  n_chk = 0, n_pass = 0;
    bit  cmp_en = 1'b0;
    int  mon_high = 0, mon_rise = 0;
    bit  mon_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    endtask

    function automatic logic [CH-1:0] m_pvec();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = (m_pulse[i] > 0);
        return v;
    endfunction

    task automatic model_reset();
        m_level = '0; m_ok = 0; m_err = 0; m_ack = 8'h00; m_idle = 0;
        fr.delete();
        for (int i = 0; i < CH; i++) m_pulse[i] = 0;
    endtask

    task automatic model_step(input bit f, input logic [7:0] d);
        int ix;
        m_ok = 0; m_err = 0;
        for (int i = 0; i < CH; i++) if (m_pulse[i] > 0) m_pulse[i]--;
        if (f) begin
            m_idle = 0;
            if (d == "#") begin
                fr.delete();
                fr.push_back(d);
            end else if (fr.size() > 0) begin
                fr.push_back(d);
                if (fr.size() == 2 && !(d >= "1" && d <= 8'("0" + CH))) m_err = 1;
                if (fr.size() == 3 && !(d inside {"S", "C", "T", "P"})) m_err = 1;
                if (fr.size() == 4) begin
                    if (d == 8'h0D || d == 8'h0A) begin
                        ix = int'(fr[1]) - int'("1");
                        case (fr[2])
                            "S": m_level[ix] = 1'b1;
                            "C": m_level[ix] = 1'b0;
                            "T": m_level[ix] = ~m_level[ix];
                            default: m_pulse[ix] = PL;
                        endcase
                        m_ok = 1;
                    end else m_err = 1;
                end
                if (m_ok || m_err) fr.delete();
            end
        end else if (fr.size() > 0 && TO > 0) begin
            m_idle++;
            if (m_idle >= ((TO > 1) ? TO - 1 : 1)) begin
                m_err = 1; m_idle = 0;
                fr.delete();
            end
        end
        if (m_ok)  m_ack = "K";
        if (m_err) m_ack = "E";
    endtask

    task automatic cycle(input bit f, input logic [7:0] d);
        @(negedge clk);
        po_flag = f;
        po_data = d;
        model_step(f, d);
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        cycle(1'b1, d);
        repeat (gap) cycle(1'b0, 8'($urandom));
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    always begin
        after_edge();
        if (cmp_en) begin
            chk("ch_level", ch_level, m_level);
            chk("ch_pulse", ch_pulse, m_pvec());
            chk("cmd_ok", cmd_ok, m_ok);
            chk("cmd_err", cmd_err, m_err);
            chk("busy", busy, fr.size() > 0);
            chk("ok_err_excl", cmd_ok & cmd_err, 0);
`ifdef RX_CMD_ACK_EN
            chk("pi_flag", pi_flag, m_ok | m_err);
            chk("pi_data", pi_data, m_ack);
`endif
        end
    end

    always begin
        after_edge();
        if (ch_pulse[0]) mon_high++;
        if (ch_pulse[0] && !mon_prev) mon_rise++;
        mon_prev = ch_pulse[0];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int rnd_gap();
        int r = $urandom_range(0, 39);
        if (r == 0) return 96 + $urandom_range(0, 6);
        if (r < 12) return 0;
        return $urandom_range(1, 3);
    endfunction

    function automatic logic [7:0] rnd_byte(input int pos);
        logic [7:0] acts [4] = '{"S", "C", "T", "P"};
        int r = $urandom_range(0, 15);
        if (r == 0) return 8'($urandom);
        if (r == 1) return "#";
        if (r == 2) return ($urandom_range(0, 1) != 0) ? 8'h30 : 8'(8'h31 + CH + $urandom_range(0, 3));
        if (r == 3) return "X";
        case (pos)
            0:       return "#";
            1:       return 8'(8'h31 + $urandom_range(0, CH - 1));
            2:       return acts[$urandom_range(0, 3)];
            default: return ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        endcase
    endfunction

    initial begin
        int n;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_level", ch_level, 0);
        chk("rst_pulse", ch_pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_okerr", {cmd_ok, cmd_err}, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Plain set, one byte per 10 cycles
        send("#", 9); send("2", 9); send("S", 9);
        cycle(1'b1, 8'h0D);
        after_edge();
        chk("t1_ok", cmd_ok, 1);
        chk("t1_level", ch_level, 4'b0010);
        cycle(1'b0, 8'h00);
        after_edge();
        chk("t1_ok_one_cycle", cmd_ok, 0);
        repeat (5) cycle(1'b0, 8'h00);

        // Pulse length and extension without a gap
        mon_high = 0; mon_rise = 0;
        send("#", 0); send("1", 0); send("P", 0); send(8'h0A, 15);
        chk("t2_pulse_len", mon_high, 8);
        chk("t2_pulse_rise", mon_rise, 1);
        mon_high = 0; mon_rise = 0;
        send("#", 0); send("1", 0); send("P", 0); send(8'h0A, 3);
        send("#", 0); send("1", 0); send("P", 0); send(8'h0A, 20);
        chk("t2_ext_len", mon_high, 15);
        chk("t2_ext_rise", mon_rise, 1);
        chk("t2_level", ch_level, 4'b0010);

        // Bad channel, then toggles
        cycle(1'b1, "#");
        cycle(1'b1, "5");
        after_edge();
        chk("t3_err", cmd_err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_level", ch_level, 4'b0010);
        send("S", 2); send(8'h0D, 2);
        send("#", 0); send("3", 0); send("T", 0); send(8'h0D, 2);
        chk("t3_tgl1", ch_level[2], 1);
        send("#", 0); send("3", 0); send("T", 0); send(8'h0D, 2);
        chk("t3_tgl2", ch_level[2], 0);

        // Inter-byte timeout
        send("#", 0);
        cycle(1'b1, "2");
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            cycle(1'b0, 8'h00);
            after_edge();
            if (cmd_err) begin n = k; break; end
        end
        chk("t4_timeout_cycle", n, 99);
        chk("t4_busy", busy, 0);
        send("#", 0); send("2", 0); send("#", 0); send("3", 0); send("S", 0); send(8'h0A, 3);
        chk("t4_restart_level", ch_level, 4'b0110);

        // Asynchronous reset mid-frame and mid-pulse
        send("#", 0); send("4", 0); send("S", 0); send(8'h0D, 0);
        send("#", 0); send("2", 0); send("P", 0); send(8'h0D, 1);
        send("#", 0); send("3", 0);
        cycle(1'b0, 8'h00);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_level", ch_level, 0);
        chk("t5_pulse", ch_pulse, 0);
        chk("t5_busy", busy, 0);
        chk("t5_okerr", {cmd_ok, cmd_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        po_flag = 1'b0;
        model_step(1'b0, 8'h00);
        repeat (4) cycle(1'b0, 8'h00);

`ifdef RX_CMD_ACK_EN
        send("#", 0); send("1", 0); send("S", 0);
        cycle(1'b1, 8'h0D);
        after_edge();
        chk("t6_ack_flag", pi_flag & cmd_ok, 1);
        chk("t6_ack_k", pi_data, 8'h4B);
        send("#", 0); send("1", 0);
        cycle(1'b1, "X");
        after_edge();
        chk("t6_nak_flag", pi_flag & cmd_err, 1);
        chk("t6_nak_e", pi_data, 8'h45);
        cycle(1'b0, 8'h00);
`endif

        // Randomized frames, corruptions, restarts and timeouts
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                for (int p = 0; p < 4; p++) send(rnd_byte(p), rnd_gap());
            end else begin
                send(rnd_byte($urandom_range(0, 3)), rnd_gap());
            end
        end
        repeat (20) cycle(1'b0, 8'h00);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
